// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard controller for F/D/E stalls and bubbles, with mult/div busy tracking; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_srcA,
    input  logic [4:0]  d_srcB,
    input  logic        D_uses_hilo,
    input  logic [4:0]  E_dstM,
    input  logic        E_mispredict,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        md_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
);
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       load_use, md_hazard;
    // a start reloads the occupancy (never accumulates); otherwise count down and hold at zero
    always_comb md_cnt_d = E_md_start ? (E_md_div ? 4'(DIV_LAT) : 4'(MUL_LAT))
                                      : md_cnt_q - {3'b0, md_cnt_q != 4'd0};
    // busy counter register
    always_ff @(posedge clk) md_cnt_q <= reset ? 4'd0 : md_cnt_d;
    assign md_busy   = md_cnt_q != 4'd0;
    assign load_use  = (E_dstM != 5'd0) && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign md_hazard = md_busy && D_uses_hilo;
    // reset and mispredict flush D/E and win over any stall; the decode instruction is dead anyway
    assign {F_stall, D_stall, D_bubble, E_bubble} = (reset || E_mispredict)  ? 4'b0011 :
                                                    (load_use || md_hazard) ? 4'b1101 : 4'b0000;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;
    // free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + {31'b0, D_stall};
            flush_q <= flush_q + {31'b0, E_mispredict};
        end
    end
    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard controller for the five-stage pipelined MIPS core. It watches the decode and execute stages and drives the stall and bubble inputs of the F/D/E pipeline registers, including the E-register `E_bubble`. It resolves three hazards:
- load-use data hazards;
- branch mispredictions;
- structural hazards on the multi-cycle multiply/divide unit, tracked by an internal busy counter.

Optional performance counters record stall and flush cycles.

## Interface
Parameters:
- MUL_LAT, default 4: multiply occupancy in cycles (1..15).
- DIV_LAT, default 12: divide occupancy in cycles (1..15).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- d_srcA  input  5  rs register read by the instruction in decode (0 = none).
- d_srcB  input  5  rt register read by the instruction in decode (0 = none).
- D_uses_hilo  input  1  decode instruction reads HI/LO or starts a mult/div.
- E_dstM  input  5  load destination of the instruction in execute (0 = not a load).
- E_mispredict  input  1  branch in execute was mispredicted.
- E_md_start  input  1  execute instruction starts mult/div this cycle.
- E_md_div  input  1  qualifies E_md_start: 1 = divide, 0 = multiply.
- F_stall  output  1  hold the fetch PC.
- D_stall  output  1  hold the D register.
- D_bubble  output  1  load a NOP into the D register.
- E_bubble  output  1  load a NOP into the E register.
- md_busy  output  1  mult/div unit occupied.
- stall_cycles  output  32  count of cycles with D_stall=1.
- flush_cycles  output  32  count of cycles with E_mispredict=1.

## Operation
- Busy counter `md_cnt`, 4 bits, registered.
  - On reset it is set to 0.
  - When E_md_start=1, it loads DIV_LAT if E_md_div=1, otherwise MUL_LAT. A new start while busy restarts the count; it does not accumulate.
  - Otherwise it decrements each cycle while nonzero and holds at 0.
  - md_busy = (md_cnt != 0). md_busy is registered and does not depend on the current E_md_start.
- load_use = (E_dstM != 0) && (E_dstM == d_srcA || E_dstM == d_srcB). Register 0 never matches.
- md_hazard = md_busy && D_uses_hilo.
- Output priority, evaluated combinationally every cycle:
  1. reset=1: F_stall=0, D_stall=0, D_bubble=1, E_bubble=1. This flushes D and E.
  2. E_mispredict=1: D_bubble=1, E_bubble=1, F_stall=0, D_stall=0. A mispredict overrides both load_use and md_hazard, because the instruction in decode is on the wrong path.
  3. load_use or md_hazard: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
  4. Otherwise all four outputs are 0.
- D_stall and D_bubble are never both 1. F_stall always equals D_stall.
- E_md_start and E_mispredict in the same cycle: the counter still loads, and the flush still occurs.

## Timing
- Hazard outputs are combinational from the inputs and md_cnt, with zero-cycle latency. The pipeline registers consume them at the next rising edge.
- A start sampled at edge n gives md_busy=1 for cycles n+1 .. n+LAT, and md_busy=0 at n+LAT+1.
- A load-use stall lasts exactly 1 cycle, because the load moves to M and E_dstM becomes 0 or an unrelated register.
- An md_hazard stall persists until md_busy falls. The decode instruction advances in the first cycle with md_busy=0.
- Reset taken mid-operation: md_cnt=0 at the next edge, and counters clear to 0.
- Output values during and after the reset edge:
  - During reset: D_bubble=1 and E_bubble=1.
  - First cycle after reset deasserts: all hazard outputs 0, provided the inputs are quiet.

## Configuration
- Macro `PIPE_CTRL_PERF_EN`.
- When defined:
  - stall_cycles increments on each edge where D_stall=1 and reset=0.
  - flush_cycles increments on each edge where E_mispredict=1 and reset=0.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both clear on reset.
- When undefined:
  - Both ports remain present but are tied to constant 0.
  - No counter flops are instantiated.

## Test plan
- Reset held for 2 cycles with E_mispredict=1 and E_dstM=d_srcA=5: D_bubble=1, E_bubble=1, F_stall=0, D_stall=0, md_busy=0. After release with quiet inputs, all outputs are 0.
- E_dstM=3, d_srcB=3 for 1 cycle: F_stall=D_stall=E_bubble=1 in that cycle. Next cycle E_dstM=0: all outputs 0. Repeating with E_dstM=0 and d_srcA=0 gives no stall.
- E_md_start=1, E_md_div=0 at edge n, then D_uses_hilo=1 held:
  - md_busy=1 for 4 cycles, with F_stall=D_stall=E_bubble=1 throughout.
  - Stalls release on cycle n+5.
  - Repeating with E_md_div=1 gives 12 busy cycles.
- E_mispredict=1 together with load_use=1 and md_hazard=1: D_bubble=E_bubble=1, F_stall=D_stall=0.
- Divide start followed 3 cycles later by a multiply start: md_busy stays 1 for exactly 4 more cycles after the second start edge, showing the count reloads rather than accumulating.
- With PIPE_CTRL_PERF_EN:
  - 3 load-use stalls and 2 mispredicts give stall_cycles=3 and flush_cycles=2.
  - Forcing the counter to 0xFFFFFFFF and adding one stall wraps it to 0.
  - Without the macro, both counters read 0 throughout.
